rv32_fetch_queue: RTL and testbench
===================================

# rv32_fetch_queue

Instruction-fetch front end that sits directly upstream of the pipelined RV32 core's IF stage. It generates sequential fetch addresses and issues them to instruction memory over a request/grant/response handshake. Returned words are buffered with their PCs in a small in-order FIFO and presented to the core under a valid/ready handshake. A redirect (taken branch or jump resolved in the core) flushes the queue, discards in-flight responses, and restarts fetch at the new PC.

## Interface

Parameters:
- DEPTH, 4: queue entries; also the cap on queued + outstanding requests (power of two, ≥2).
- PC_RESET_VALUE, 32'h00000000: first fetch address after reset.

Ports:
- Clock and reset:
  - clk  input  1  single clock; all state updates on its rising edge.
  - rst_n  input  1  reset, asynchronous and active-low.
- Redirect:
  - redirect_valid  input  1  flush and restart fetch this cycle.
  - redirect_pc  input  32  new fetch address; bits [1:0] are ignored and treated as 0.
- Instruction memory:
  - imem_req  output  1  fetch request.
  - imem_addr  output  32  word-aligned fetch address.
  - imem_gnt  input  1  request accepted this cycle.
  - imem_rvalid  input  1  response data valid.
  - imem_rdata  input  32  instruction word.
- Core:
  - instr_valid  output  1  head entry valid.
  - instr  output  32  head instruction.
  - instr_pc  output  32  PC of head instruction.
  - instr_ready  input  1  core consumes the head entry.

## Operation

- **State**
  - fetch_pc: next address to request.
  - resp_pc: PC of the next live response.
  - outstanding: granted requests awaiting rvalid, 0..DEPTH.
  - discard: stale responses still to drop, ≤ outstanding.
  - FIFO of {instr, pc} with count 0..DEPTH.
- **Request**
  - imem_req = !redirect_valid && (count + outstanding < DEPTH), using current-cycle values; it never speculates on a same-cycle pop.
  - imem_addr = fetch_pc.
  - Grant = imem_req && imem_gnt; on grant, fetch_pc += 4 (wraps modulo 2^32) and outstanding increments.
  - While imem_req is high and not granted, imem_addr holds. A redirect may withdraw a pending request; the memory side does not depend on a withdrawn request.
- **Response**
  - Responses are in order and arrive at least 1 cycle after grant.
  - On imem_rvalid, outstanding decrements.
  - If discard > 0: drop the data and decrement discard.
  - Otherwise: push {imem_rdata, resp_pc} and add 4 to resp_pc.
  - imem_rvalid with outstanding == 0 is a protocol violation; it is ignored and changes no state.
- **Output**
  - instr_valid = count != 0; instr and instr_pc show the FIFO head.
  - Pop on instr_valid && instr_ready.
  - Push and pop in the same cycle leave count unchanged.
- **Redirect** (highest priority)
  - FIFO is emptied and any same-cycle pop or push is cancelled.
  - fetch_pc and resp_pc are set to {redirect_pc[31:2], 2'b00}.
  - discard is set to outstanding − imem_rvalid, which is every response still pending after this cycle.
  - No grant is possible in the redirect cycle because imem_req is low.
- **Reset values**
  - imem_req = 0 while rst_n is low.
  - fetch_pc = resp_pc = PC_RESET_VALUE, so imem_addr = PC_RESET_VALUE.
  - count, outstanding and discard = 0.
  - instr_valid = 0; instr = 0 and instr_pc = 0, as FIFO storage resets to 0.
- **Reset mid-operation:** all in-flight state is lost. The memory side is reset together with this block.

## Timing

- **Best case:** request granted at cycle T, rvalid at T+1, instr_valid at T+2. Data is always registered; there is no rvalid→instr_valid bypass.
- **Redirect at cycle R:**
  - instr_valid is low at R+1.
  - imem_req is high at R+1 with imem_addr = redirect_pc.
  - Earliest valid redirected instruction is at R+3.
- **Back-to-back:** with a grant every cycle, 1-cycle response latency and instr_ready held high, the queue sustains one instruction per cycle.
- **Full:** count + outstanding == DEPTH forces imem_req low until a pop occurs. imem_req rises the cycle after that pop.
- **Back-pressure:** instr_ready low holds instr and instr_pc stable while instr_valid is high.

## Test plan

- **Reset and stream:** release rst_n with gnt=1 always and 1-cycle rvalid latency. Expect imem_addr 0x0, 0x4, 0x8, ..., and instr_pc 0x0, 0x4, 0x8 on consecutive cycles from the 3rd cycle after reset release, with instr matching the memory image.
- **Back-pressure:** hold instr_ready=0. Expect exactly 4 grants, then imem_req low, head stable at pc 0x0. Raise instr_ready for one cycle: head becomes pc 0x4 and exactly one new request (addr 0x10) issues.
- **Redirect with in-flight responses:** 3-cycle response latency, 2 requests outstanding, pulse redirect to 0x100. Expect the 2 stale responses dropped, imem_req low in the redirect cycle, first delivered instr_pc = 0x100, and no stale instructions on the output.
- **Redirect coinciding with rvalid and pop:** expect that rvalid dropped, the pop cancelled, and discard = outstanding − 1.
- **Wrap-around:** redirect to 0xFFFFFFF8. Expect PCs 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000 in order; also redirect to 0x103 and expect fetch at 0x100.
- **Async reset mid-stream:** assert rst_n low between clock edges. Expect imem_req and instr_valid low immediately, and fetch restarting at PC_RESET_VALUE after release.

Source files
------------

// File: rtl/rv32_fetch_queue.sv
// Instruction-fetch front end: sequential address generation, request/grant/response
// handshake to instruction memory, and an in-order {instr, pc} queue toward the core.
module rv32_fetch_queue #(
  parameter int unsigned DEPTH          = 4,
  parameter logic [31:0] PC_RESET_VALUE = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [31:0]   instr_mem_q [DEPTH];
  logic [31:0]   pc_mem_q    [DEPTH];

  logic          grant, rsp, push, pop;
  logic [CW:0]   occupancy;
  logic [31:0]   redirect_pc_al;

  assign redirect_pc_al = redirect_pc & 32'hFFFF_FFFC;
  assign occupancy      = {1'b0, count_q} + {1'b0, outst_q};

  // Request gated by rst_n so it drops immediately on an async reset assertion.
  assign imem_req  = rst_n && !redirect_valid && (occupancy < DEPTH_W);
  assign imem_addr = fetch_pc_q;
  assign grant     = imem_req && imem_gnt;

  // A response with nothing outstanding is a protocol violation and is ignored.
  assign rsp  = imem_rvalid && (outst_q != '0);
  assign push = rsp && (discard_q == '0) && !redirect_valid;

  assign instr_valid = (count_q != '0);
  assign instr       = instr_mem_q[rptr_q];
  assign instr_pc    = pc_mem_q[rptr_q];
  assign pop         = instr_valid && instr_ready && !redirect_valid;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    discard_d  = discard_q;
    outst_d    = outst_q + CW'(grant) - CW'(rsp);
    count_d    = count_q + CW'(push) - CW'(pop);

    if (grant) fetch_pc_d = fetch_pc_q + 32'd4;
    if (rsp && (discard_q != '0)) discard_d = discard_q - CW'(1);
    if (push) begin
      resp_pc_d = resp_pc_q + 32'd4;
      wptr_d    = wptr_q + PW'(1);
    end
    if (pop) rptr_d = rptr_q + PW'(1);

    // Every response still pending after this cycle belongs to the old stream.
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc_al;
      resp_pc_d  = redirect_pc_al;
      discard_d  = outst_q - CW'(rsp);
      count_d    = '0;
      wptr_d     = '0;
      rptr_d     = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= PC_RESET_VALUE;
      resp_pc_q  <= PC_RESET_VALUE;
      count_q    <= '0;
      outst_q    <= '0;
      discard_q  <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        instr_mem_q[i] <= '0;
        pc_mem_q[i]    <= '0;
      end
    end else if (push) begin
      instr_mem_q[wptr_q] <= imem_rdata;
      pc_mem_q[wptr_q]    <= resp_pc_q;
    end
  end

endmodule

// File: tb/tb_rv32_fetch_queue.sv
// Randomized bench for rv32_fetch_queue: an in-order memory model with variable latency,
// and an epoch-tagged reference queue predicting the instruction stream seen by the core.
module tb_rv32_fetch_queue;

  localparam int          DEPTH  = 4;
  localparam logic [31:0] PC_RST = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready = 1'b0;

  rv32_fetch_queue #(.DEPTH(DEPTH), .PC_RESET_VALUE(PC_RST)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_ready   (instr_ready)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int epoch; int due; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] ins; } ent_t;

  req_t        pend[$];
  ent_t        refq[$];
  int          epoch = 0;
  int          cyc = 0;
  int          grants = 0;
  logic [31:0] ref_fetch = PC_RST;

  int gnt_pct = 100, rdy_pct = 100, redir_pct = 0, spur_pct = 0;
  int lat_min = 1, lat_max = 1;
  logic        force_redir = 1'b0;
  logic [31:0] force_pc = '0;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] img(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic logic [31:0] rand_pc();
    case ($urandom_range(3))
      0:       return $urandom();
      1:       return 32'hFFFF_FFF0 + {28'd0, 4'($urandom_range(15))};
      default: return 32'($urandom_range(1023));
    endcase
  endfunction

  task automatic step();
    ent_t e;
    req_t h;
    logic exp_req, rsp, live;
    @(posedge clk);
    #1;
    cyc++;
    imem_gnt    = ($urandom_range(99) < gnt_pct);
    instr_ready = ($urandom_range(99) < rdy_pct);
    if (force_redir) begin
      redirect_valid = 1'b1;
      redirect_pc    = force_pc;
      force_redir    = 1'b0;
    end else begin
      redirect_valid = ($urandom_range(99) < redir_pct);
      redirect_pc    = rand_pc();
    end
    imem_rdata = $urandom();
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = img(pend[0].addr);
    end else if (pend.size() == 0 && $urandom_range(99) < spur_pct) begin
      imem_rvalid = 1'b1;
    end else begin
      imem_rvalid = 1'b0;
    end

    @(negedge clk);
    exp_req = !redirect_valid && ((refq.size() + pend.size()) < DEPTH);
    chk("imem_req", 32'(imem_req), 32'(exp_req));
    if (exp_req) chk("imem_addr", imem_addr, ref_fetch);
    chk("instr_valid", 32'(instr_valid), 32'(refq.size() != 0));
    if (refq.size() != 0) begin
      chk("instr_pc", instr_pc, refq[0].pc);
      chk("instr", instr, refq[0].ins);
    end

    rsp  = imem_rvalid && (pend.size() > 0);
    live = 1'b0;
    if (rsp) begin
      h = pend.pop_front();
      if (h.epoch == epoch && !redirect_valid) begin
        live = 1'b1;
        e.pc  = h.addr;
        e.ins = img(h.addr);
      end
    end
    if (!redirect_valid && instr_ready && refq.size() != 0) void'(refq.pop_front());
    if (live) refq.push_back(e);
    if (exp_req && imem_gnt) begin
      pend.push_back('{addr: ref_fetch, epoch: epoch, due: cyc + $urandom_range(lat_max, lat_min)});
      ref_fetch = ref_fetch + 32'd4;
      grants++;
    end
    if (redirect_valid) begin
      refq.delete();
      epoch++;
      ref_fetch = redirect_pc & 32'hFFFF_FFFC;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_knobs(input int g, input int r, input int rd, input int sp,
                           input int lmin, input int lmax);
    gnt_pct = g; rdy_pct = r; redir_pct = rd; spur_pct = sp; lat_min = lmin; lat_max = lmax;
  endtask

  task automatic idle_inputs();
    imem_gnt = 1'b0; imem_rvalid = 1'b0; redirect_valid = 1'b0; instr_ready = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_req"}, 32'(imem_req), 32'd0);
    chk({tag, "_valid"}, 32'(instr_valid), 32'd0);
    chk({tag, "_addr"}, imem_addr, PC_RST);
    chk({tag, "_instr"}, instr, 32'd0);
    chk({tag, "_pc"}, instr_pc, 32'd0);
  endtask

  task automatic async_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    idle_inputs();
    #1;
    chk("arst_req_now", 32'(imem_req), 32'd0);
    chk("arst_valid_now", 32'(instr_valid), 32'd0);
    pend.delete();
    refq.delete();
    epoch++;
    ref_fetch = PC_RST;
    @(negedge clk);
    check_reset_state("arst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    idle_inputs();
    #12;
    check_reset_state("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Streaming from reset: grant always, 1-cycle latency, core always ready.
    set_knobs(100, 100, 0, 0, 1, 1);
    grants = 0;
    run(20);
    chk("stream_grants", grants, 20);

    // Back-pressure from a fresh reset.
    async_reset();
    set_knobs(100, 0, 0, 0, 1, 1);
    grants = 0;
    run(10);
    chk("bp_grants", grants, 4);
    chk("bp_head_pc", instr_pc, 32'h0);
    rdy_pct = 100;
    run(1);
    rdy_pct = 0;
    run(4);
    chk("bp_grants_after_pop", grants, 5);
    chk("bp_head_pc_after_pop", instr_pc, 32'h4);

    // Redirect while responses are in flight.
    set_knobs(100, 100, 0, 0, 3, 3);
    run(8);
    force_redir = 1'b1;
    force_pc = 32'h0000_0100;
    run(14);

    // Wrap-around and unaligned redirect target.
    set_knobs(100, 100, 0, 0, 1, 1);
    force_redir = 1'b1;
    force_pc = 32'hFFFF_FFF8;
    run(10);
    force_redir = 1'b1;
    force_pc = 32'h0000_0103;
    run(8);

    // Randomized traffic with varied pressure and latency.
    set_knobs(70, 70, 5, 5, 1, 4);
    run(1500);
    set_knobs(100, 100, 10, 0, 1, 1);
    run(800);
    set_knobs(40, 30, 3, 5, 1, 6);
    run(1500);

    async_reset();
    set_knobs(80, 80, 4, 5, 1, 3);
    run(1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
